calculadora_ctrl: RTL and testbench
===================================

Name: calculadora_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 8-bit adder/subtractor (`somador_subtrator`) in the calculator datapath.
- Captures operand A, operand B and the operation from board switches on successive button presses.
- Drives the adder's a/b/sel inputs, registers its result and carry, and converts the result to 3-digit BCD for the 7-segment display stage.

Parameters:
- LARGURA, 8, operand/result width; only 8 is supported (BCD output sized for 0..255).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- chaves  in  8  operand switches, sampled on a confirm press
- op  in  1  operation switch: 0 soma, 1 subtração
- confirma  in  1  debounced button level, synchronous to clk
- limpa  in  1  synchronous clear, active-high
- a_out  out  8  operand A to adder
- b_out  out  8  operand B to adder
- sel_out  out  1  operation select to adder
- res_in  in  8  adder result (combinational return)
- cout_in  in  1  adder carry-out
- resultado  out  8  registered result
- bcd  out  12  {centenas, dezenas, unidades}, 4 bits each
- flag_carry  out  1  soma: cout_in; subtração: ~cout_in (borrow, A<B)
- pronto  out  1  high while result and BCD are valid (state MOSTRA)
- estado  out  3  current state encoding (debug LEDs)

Behaviour:
- Press detection:
  - `press = confirma & ~confirma_d`.
  - `confirma_d` is registered every cycle and resets to 1, so a button held through reset does not fire.
  - One press per rising edge of confirma; a held level gives exactly one press.
- Reset (rst=1):
  - State goes to ESPERA_A (0).
  - a_out, b_out, sel_out, resultado, bcd, flag_carry, pronto are all 0.
  - The converter goes idle.
  - rst overrides everything, including mid-conversion.
- limpa=1 (rst=0): same clears as reset, except `confirma_d` keeps updating normally. limpa has priority over press.
- States and transitions:
  - ESPERA_A (0): on press, a_out<=chaves, go to ESPERA_B.
  - ESPERA_B (1): on press, b_out<=chaves, go to ESPERA_OP.
  - ESPERA_OP (2): on press, sel_out<=op, go to CALCULA.
  - CALCULA (3): one cycle, unconditional.
    - At the exit edge: resultado<=res_in and flag_carry<=(sel_out ? ~cout_in : cout_in).
    - The converter is started with res_in; go to CONVERTE.
  - CONVERTE (4): waits for the converter's `done`. At that edge, bcd<=converter output; go to MOSTRA.
  - MOSTRA (5): pronto=1. On press, go to ESPERA_A; pronto drops.
  - Encodings 6–7: go to ESPERA_A next cycle.
- Presses in CALCULA/CONVERTE are ignored (not queued).
- Output holding:
  - a_out/b_out/sel_out hold until overwritten, so res_in stays stable through CALCULA.
  - resultado/bcd/flag_carry hold their last values through ESPERA_* until the next CALCULA/CONVERTE overwrites them.
- Latency: the press edge enters CALCULA at edge E0. resultado is valid after E1, converter shifts occur at E2..E9, and MOSTRA/pronto/bcd are valid after E10.
- Arithmetic:
  - Results wrap modulo 256 with no saturation; e.g. 5−10 → 251 with flag_carry=1.
  - BCD always represents resultado as an unsigned value.
- Converter (double-dabble):
  - `start` loads the value and clears the 12-bit BCD accumulator.
  - Then performs exactly 8 iterations, one per cycle: add 3 to any digit ≥5, then shift left by one bit.
  - `done` is registered high for one cycle after the 8th iteration.
  - A start while busy restarts the conversion.

Decomposition:
- Shared package `calc_pkg`:
  - State encodings ESPERA_A..MOSTRA (3-bit).
  - LARGURA=8, BCD width 12, iteration count 8.
- Sub-module `bin2bcd_seq` (clk, rst, start, bin[7:0], bcd[11:0], done), instantiated once.
- The adder/subtractor stays external; it is connected at the top level via a_out/b_out/sel_out/res_in/cout_in.

Test Plan:
- Press sequence A=100, B=55, op=0 with a real somador_subtrator attached → resultado=155, flag_carry=0, bcd=0x155, pronto high exactly 10 cycles after entering CALCULA.
- A=200, B=100, op=0 → resultado=44, flag_carry=1, bcd=0x044.
- A=10, B=5, op=1 → resultado=5, flag_carry=0, bcd=0x005. Then A=5, B=10, op=1 → resultado=251, flag_carry=1, bcd=0x251.
- Hold confirma high for 20 cycles in ESPERA_A → a_out captured once, state=ESPERA_B (not ESPERA_OP). confirma held high across rst deassert → no capture.
- Assert limpa during CONVERTE (cycle E5) → next cycle state=0 with all outputs 0. Pressing in CALCULA/CONVERTE → no state change; the full sequence then completes normally.
- Assert rst in MOSTRA with bcd=0x155 → all outputs 0 next cycle. Force estado to 6 (via a bench bind/force) → state returns to ESPERA_A the next cycle.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_pkg : shared state encodings and sizing for the calculator controller
// Rev 1.0
// ----------------------------------------------------------------------------
package calc_pkg;

  localparam int LARGURA = 8;
  localparam int BCD_W   = 12;
  localparam int N_ITER  = 8;

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_B  = 3'd1,
    ESPERA_OP = 3'd2,
    CALCULA   = 3'd3,
    CONVERTE  = 3'd4,
    MOSTRA    = 3'd5
  } estado_t;

  // Double-dabble digit correction applied before each shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/calculadora_ctrl_bin2bcd.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bin2bcd_seq : sequential 8-bit binary to 3-digit BCD (double-dabble)
// Rev 1.0
// ----------------------------------------------------------------------------
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [7:0]       bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // A start while busy simply restarts the conversion.
        bin_q  <= bin;
        bcd_q  <= '0;
        cnt_q  <= 4'(N_ITER);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_q          <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/calculadora_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calculadora_ctrl : captures A/B/op from switches, drives the external adder,
//                    registers its result and converts it to BCD for display
// Rev 1.0
// ----------------------------------------------------------------------------
module calculadora_ctrl #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] chaves,
  input  logic               op,
  input  logic               confirma,
  input  logic               limpa,
  output logic [LARGURA-1:0] a_out,
  output logic [LARGURA-1:0] b_out,
  output logic               sel_out,
  input  logic [LARGURA-1:0] res_in,
  input  logic               cout_in,
  output logic [LARGURA-1:0] resultado,
  output logic [11:0]        bcd,
  output logic               flag_carry,
  output logic               pronto,
  output logic [2:0]         estado
);

  import calc_pkg::*;

  estado_t            state_q, state_d;
  logic               confirma_q;
  logic [LARGURA-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic               sel_q, sel_d, carry_q, carry_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic               press;
  logic               conv_start;
  logic               conv_rst;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  assign press    = confirma & ~confirma_q;
  assign conv_rst = rst | limpa;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (conv_rst),
    .start (conv_start),
    .bin   (res_in),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    res_d      = res_q;
    carry_d    = carry_q;
    bcd_d      = bcd_q;
    conv_start = 1'b0;
    if (limpa) begin
      state_d = ESPERA_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = 1'b0;
      res_d   = '0;
      carry_d = 1'b0;
      bcd_d   = '0;
    end else begin
      case (state_q)
        ESPERA_A: if (press) begin
          a_d     = chaves;
          state_d = ESPERA_B;
        end
        ESPERA_B: if (press) begin
          b_d     = chaves;
          state_d = ESPERA_OP;
        end
        ESPERA_OP: if (press) begin
          sel_d   = op;
          state_d = CALCULA;
        end
        CALCULA: begin
          // Subtraction carry-out is the inverted borrow, so flip it back.
          res_d      = res_in;
          carry_d    = sel_q ? ~cout_in : cout_in;
          conv_start = 1'b1;
          state_d    = CONVERTE;
        end
        CONVERTE: if (conv_done) begin
          bcd_d   = conv_bcd;
          state_d = MOSTRA;
        end
        MOSTRA: if (press) begin
          state_d = ESPERA_A;
        end
        default: state_d = ESPERA_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ESPERA_A;
      confirma_q <= 1'b1;   // a button held through reset must not fire
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= 1'b0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      confirma_q <= confirma;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      bcd_q      <= bcd_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign sel_out    = sel_q;
  assign resultado  = res_q;
  assign flag_carry = carry_q;
  assign bcd        = bcd_q;
  assign pronto     = (state_q == MOSTRA);
  assign estado     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_calculadora_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_calculadora_ctrl : directed bench with a behavioural adder/subtractor
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_calculadora_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  chaves = '0;
  logic        op = 1'b0;
  logic        confirma = 1'b0;
  logic        limpa = 1'b0;
  logic [7:0]  a_out, b_out, res_in, resultado;
  logic        sel_out, cout_in, flag_carry, pronto;
  logic [11:0] bcd;
  logic [2:0]  estado;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in for somador_subtrator: subtraction as A + ~B + 1.
  always_comb begin
    if (sel_out) {cout_in, res_in} = {1'b0, a_out} + {1'b0, ~b_out} + 9'd1;
    else         {cout_in, res_in} = {1'b0, a_out} + {1'b0, b_out};
  end

  calculadora_ctrl #(.LARGURA(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .chaves     (chaves),
    .op         (op),
    .confirma   (confirma),
    .limpa      (limpa),
    .a_out      (a_out),
    .b_out      (b_out),
    .sel_out    (sel_out),
    .res_in     (res_in),
    .cout_in    (cout_in),
    .resultado  (resultado),
    .bcd        (bcd),
    .flag_carry (flag_carry),
    .pronto     (pronto),
    .estado     (estado)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        op;
    logic [7:0]  res;
    logic        cy;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic press(input logic [7:0] v, input logic o);
    @(negedge clk);
    chaves   = v;
    op       = o;
    confirma = 1'b1;
    @(negedge clk);
    confirma = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " estado"}, 32'(estado), 32'd0);
    chk({tag, " a_out"}, 32'(a_out), 32'd0);
    chk({tag, " b_out"}, 32'(b_out), 32'd0);
    chk({tag, " sel_out"}, 32'(sel_out), 32'd0);
    chk({tag, " resultado"}, 32'(resultado), 32'd0);
    chk({tag, " bcd"}, 32'(bcd), 32'd0);
    chk({tag, " flag_carry"}, 32'(flag_carry), 32'd0);
    chk({tag, " pronto"}, 32'(pronto), 32'd0);
  endtask

  // Starts at the negedge after CONVERTE entry (lat=1); returns cycles from CALCULA entry to pronto.
  task automatic wait_pronto(inout int lat);
    while (!pronto && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;

    vecs[0] = '{a: 8'd100, b: 8'd55,  op: 1'b0, res: 8'd155, cy: 1'b0, bcd: 12'h155};
    vecs[1] = '{a: 8'd200, b: 8'd100, op: 1'b0, res: 8'd44,  cy: 1'b1, bcd: 12'h044};
    vecs[2] = '{a: 8'd10,  b: 8'd5,   op: 1'b1, res: 8'd5,   cy: 1'b0, bcd: 12'h005};
    vecs[3] = '{a: 8'd5,   b: 8'd10,  op: 1'b1, res: 8'd251, cy: 1'b1, bcd: 12'h251};
    vecs[4] = '{a: 8'd255, b: 8'd255, op: 1'b0, res: 8'd254, cy: 1'b1, bcd: 12'h254};
    vecs[5] = '{a: 8'd0,   b: 8'd0,   op: 1'b1, res: 8'd0,   cy: 1'b0, bcd: 12'h000};

    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      press(vecs[i].a, 1'b0);
      press(vecs[i].b, 1'b0);
      press(8'h00, vecs[i].op);
      chk($sformatf("v%0d estado CALCULA", i), 32'(estado), 32'd3);
      @(negedge clk);
      lat = 1;
      chk($sformatf("v%0d estado CONVERTE", i), 32'(estado), 32'd4);
      chk($sformatf("v%0d resultado", i), 32'(resultado), 32'(vecs[i].res));
      chk($sformatf("v%0d flag_carry", i), 32'(flag_carry), 32'(vecs[i].cy));
      wait_pronto(lat);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd10);
      chk($sformatf("v%0d estado MOSTRA", i), 32'(estado), 32'd5);
      chk($sformatf("v%0d bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      chk($sformatf("v%0d a_out", i), 32'(a_out), 32'(vecs[i].a));
      chk($sformatf("v%0d b_out", i), 32'(b_out), 32'(vecs[i].b));
      chk($sformatf("v%0d sel_out", i), 32'(sel_out), 32'(vecs[i].op));
      press(8'h00, 1'b0);
      chk($sformatf("v%0d back to ESPERA_A", i), 32'(estado), 32'd0);
      chk($sformatf("v%0d pronto drops", i), 32'(pronto), 32'd0);
      chk($sformatf("v%0d resultado held", i), 32'(resultado), 32'(vecs[i].res));
      chk($sformatf("v%0d bcd held", i), 32'(bcd), 32'(vecs[i].bcd));
    end

    // Held button: exactly one capture, later switch changes ignored.
    @(negedge clk);
    chaves   = 8'd77;
    confirma = 1'b1;
    @(negedge clk);
    chaves = 8'd88;
    repeat (19) @(negedge clk);
    chk("hold a_out", 32'(a_out), 32'd77);
    chk("hold estado", 32'(estado), 32'd1);
    confirma = 1'b0;

    // Button held across reset release must not fire.
    @(negedge clk);
    rst      = 1'b1;
    confirma = 1'b1;
    chaves   = 8'd33;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst-held estado", 32'(estado), 32'd0);
    chk("rst-held a_out", 32'(a_out), 32'd0);
    confirma = 1'b0;

    // limpa during CONVERTE, cycle E5.
    press(8'd120, 1'b0);
    press(8'd30, 1'b0);
    press(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre-limpa estado", 32'(estado), 32'd4);
    limpa = 1'b1;
    @(negedge clk);
    limpa = 1'b0;
    chk_cleared("limpa");
    repeat (12) @(negedge clk);
    chk("post-limpa pronto", 32'(pronto), 32'd0);
    chk("post-limpa bcd", 32'(bcd), 32'd0);

    // Presses during CONVERTE are ignored; sequence still completes on time.
    press(8'd100, 1'b0);
    press(8'd55, 1'b0);
    press(8'h00, 1'b0);
    @(negedge clk);
    lat = 1;
    confirma = 1'b1;
    @(negedge clk); lat++;
    confirma = 1'b0;
    @(negedge clk); lat++;
    confirma = 1'b1;
    @(negedge clk); lat++;
    confirma = 1'b0;
    chk("busy-press estado", 32'(estado), 32'd4);
    wait_pronto(lat);
    chk("busy-press latency", 32'(lat), 32'd10);
    chk("busy-press resultado", 32'(resultado), 32'd155);
    chk("busy-press bcd", 32'(bcd), 32'h155);
    chk("busy-press flag", 32'(flag_carry), 32'd0);

    // rst in MOSTRA clears everything.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cleared("rst-mostra");

    // Illegal encoding recovers to ESPERA_A.
    @(negedge clk);
    force dut.state_q = calc_pkg::estado_t'(3'd6);
    #1;
    release dut.state_q;
    #1;
    chk("forced estado", 32'(estado), 32'd6);
    @(negedge clk);
    chk("illegal recovers", 32'(estado), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
